// File: rtl/score_event_scheduler.sv
// score_event_scheduler
// Owns both players' two-digit BCD scores and shares one sound unit between
// the two paddles' hit events. Hit pulses are queued in saturating 2-bit
// pending counters and serviced one at a time. Ties between players are
// broken round-robin. Each service is one score increment followed by one
// PlayAgain request.
//
// Ports:
//   Clock           in   system clock; all state changes on its rising edge
//   pointresetShot1 in   asynchronous active-high reset, clears all state
//   hitShot1/2      in   one-cycle hit pulses from player 1 / player 2
//   clr2            in   synchronous clear of player-2 score and pending count
//   sound_busy      in   sound unit is playing; stalls the WAIT_SND state
//   Number1/2       out  player-1 tens/units BCD digits
//   Number12/22     out  player-2 tens/units BCD digits
//   PlayAgain       out  sound request, high for SOUND_HOLD cycles per event
//   grant           out  one-hot service indicator (bit0 = P1, bit1 = P2)
//   overflow        out  sticky: a hit arrived while that player's queue was full
module score_event_scheduler #(
  parameter int SOUND_HOLD = 4
) (
  input  logic       Clock,
  input  logic       pointresetShot1,
  input  logic       hitShot1,
  input  logic       hitShot2,
  input  logic       clr2,
  input  logic       sound_busy,
  output logic [3:0] Number1,
  output logic [3:0] Number2,
  output logic [3:0] Number12,
  output logic [3:0] Number22,
  output logic       PlayAgain,
  output logic [1:0] grant,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    UPDATE   = 2'd1,
    WAIT_SND = 2'd2,
    PLAY     = 2'd3
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(SOUND_HOLD - 1);

  state_t      state_r, state_nx_s;
  logic        sel_r, sel_nx_s;      // 0 = player 1, 1 = player 2
  logic        last_r, last_nx_s;    // player granted most recently
  logic [3:0]  hold_r, hold_nx_s;
  logic [1:0]  pend1_r, pend2_r;
  logic [2:0]  pend1_upd_s, pend2_upd_s;
  logic [7:0]  score1_r, score2_r;   // {tens, units}
  logic        upd1_s, upd2_s;
  logic        play_again_r;
  logic [1:0]  grant_r;
  logic        overflow_r;

  // BCD increment of a two-digit value; 99 wraps to 00. Out-of-range digits
  // are treated as 9 so a digit can never leave 0..9.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    if (v[3:0] >= 4'd9) begin
      units = 4'd0;
      if (v[7:4] >= 4'd9) begin
        tens = 4'd0;
      end else begin
        tens = v[7:4] + 4'd1;
      end
    end else begin
      units = v[3:0] + 4'd1;
      tens  = v[7:4];
    end
    return {tens, units};
  endfunction

  // Saturating pending-count update. Returns {overflow_event, next_count}.
  // A hit and a decrement together cancel out.
  function automatic logic [2:0] pend_next(input logic [1:0] p, input logic hit,
                                           input logic dec);
    logic [2:0] r;
    case ({hit, dec})
      2'b10: begin
        if (p == 2'd3) begin
          r = {1'b1, 2'd3};
        end else begin
          r = {1'b0, p + 2'd1};
        end
      end
      2'b01: begin
        // A clr2 between arbitration and UPDATE can leave the count at 0.
        if (p == 2'd0) begin
          r = {1'b0, 2'd0};
        end else begin
          r = {1'b0, p - 2'd1};
        end
      end
      default: r = {1'b0, p};
    endcase
    return r;
  endfunction

  assign upd1_s = (state_r == UPDATE) && (sel_r == 1'b0);
  assign upd2_s = (state_r == UPDATE) && (sel_r == 1'b1);

  assign pend1_upd_s = pend_next(pend1_r, hitShot1, upd1_s);
  assign pend2_upd_s = pend_next(pend2_r, hitShot2, upd2_s);

  // Next-state, arbitration and hold-counter logic.
  always_comb begin
    state_nx_s = state_r;
    sel_nx_s   = sel_r;
    last_nx_s  = last_r;
    hold_nx_s  = hold_r;
    case (state_r)
      IDLE: begin
        if ((pend1_r != 2'd0) && (pend2_r != 2'd0)) begin
          state_nx_s = UPDATE;
          sel_nx_s   = ~last_r;
          last_nx_s  = ~last_r;
        end else if (pend1_r != 2'd0) begin
          state_nx_s = UPDATE;
          sel_nx_s   = 1'b0;
          last_nx_s  = 1'b0;
        end else if (pend2_r != 2'd0) begin
          state_nx_s = UPDATE;
          sel_nx_s   = 1'b1;
          last_nx_s  = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      UPDATE: begin
        state_nx_s = WAIT_SND;
      end
      WAIT_SND: begin
        if (sound_busy) begin
          state_nx_s = WAIT_SND;
        end else begin
          state_nx_s = PLAY;
          hold_nx_s  = 4'd0;
        end
      end
      PLAY: begin
        if (hold_r >= HOLD_LAST) begin
          state_nx_s = IDLE;
          hold_nx_s  = 4'd0;
        end else begin
          hold_nx_s  = hold_r + 4'd1;
        end
      end
      default: begin
        state_nx_s = IDLE;
        hold_nx_s  = 4'd0;
      end
    endcase
  end

  // FSM state, latched choice, round-robin pointer and hold counter.
  always_ff @(posedge Clock or posedge pointresetShot1) begin
    if (pointresetShot1) begin
      state_r <= IDLE;
      sel_r   <= 1'b0;
      last_r  <= 1'b1;
      hold_r  <= 4'd0;
    end else begin
      state_r <= state_nx_s;
      sel_r   <= sel_nx_s;
      last_r  <= last_nx_s;
      hold_r  <= hold_nx_s;
    end
  end

  // Pending counters and sticky overflow; clr2 wins over player-2 activity.
  always_ff @(posedge Clock or posedge pointresetShot1) begin
    if (pointresetShot1) begin
      pend1_r    <= 2'd0;
      pend2_r    <= 2'd0;
      overflow_r <= 1'b0;
    end else begin
      pend1_r <= pend1_upd_s[1:0];
      if (clr2) begin
        pend2_r    <= 2'd0;
        overflow_r <= overflow_r | pend1_upd_s[2];
      end else begin
        pend2_r    <= pend2_upd_s[1:0];
        overflow_r <= overflow_r | pend1_upd_s[2] | pend2_upd_s[2];
      end
    end
  end

  // BCD scores; increments happen in UPDATE, clr2 wins for player 2.
  always_ff @(posedge Clock or posedge pointresetShot1) begin
    if (pointresetShot1) begin
      score1_r <= 8'h00;
      score2_r <= 8'h00;
    end else begin
      if (upd1_s) begin
        score1_r <= bcd_inc(score1_r);
      end else begin
        score1_r <= score1_r;
      end
      if (clr2) begin
        score2_r <= 8'h00;
      end else if (upd2_s) begin
        score2_r <= bcd_inc(score2_r);
      end else begin
        score2_r <= score2_r;
      end
    end
  end

  // Registered PlayAgain and grant, decoded from the upcoming state.
  always_ff @(posedge Clock or posedge pointresetShot1) begin
    if (pointresetShot1) begin
      play_again_r <= 1'b0;
      grant_r      <= 2'b00;
    end else begin
      play_again_r <= (state_nx_s == PLAY);
      if (state_nx_s == UPDATE) begin
        grant_r <= sel_nx_s ? 2'b10 : 2'b01;
      end else begin
        grant_r <= 2'b00;
      end
    end
  end

  assign Number1   = score1_r[7:4];
  assign Number2   = score1_r[3:0];
  assign Number12  = score2_r[7:4];
  assign Number22  = score2_r[3:0];
  assign PlayAgain = play_again_r;
  assign grant     = grant_r;
  assign overflow  = overflow_r;

endmodule

// File: doc/score_event_scheduler.md
# score_event_scheduler

Synchronous scheduler that owns both players' two-digit BCD scores and shares the single sound unit between the two paddles' hit events. It accepts one-shot hit pulses from both players, queues them in small per-player pending counters, and services them one at a time with round-robin arbitration. Each service is one score increment followed by one PlayAgain request to the sound unit. It sits between the game unit's one-shot pulse generators and the 7-segment score renderers and sound player, and replaces score counters clocked directly by event pulses.

## Interface
- SOUND_HOLD, 4: cycles PlayAgain is held high per serviced event (legal range 1..15).
- Clock  in  1  100 MHz system clock; all state changes on its rising edge.
- pointresetShot1  in  1  reset, asynchronous, active-high; clears all state.
- hitShot1  in  1  player-1 hit pulse, one cycle wide, synchronous to Clock.
- hitShot2  in  1  player-2 hit pulse, one cycle wide, synchronous to Clock.
- clr2  in  1  synchronous clear of player-2 score and pending count (driven by pointresetShot2).
- sound_busy  in  1  high while the sound unit is playing.
- Number1  out  4  player-1 tens digit (BCD).
- Number2  out  4  player-1 units digit (BCD).
- Number12  out  4  player-2 tens digit (BCD).
- Number22  out  4  player-2 units digit (BCD).
- PlayAgain  out  1  registered sound request, high only in state PLAY.
- grant  out  2  one-hot service indicator: bit0 = player 1, bit1 = player 2; high only in state UPDATE.
- overflow  out  1  sticky flag: a hit arrived while that player's pending count was already 3.

## Operation
- Pending counters pend1 and pend2 are 2-bit and saturate at 3.
  - A hit increments the player's counter.
  - A hit arriving at 3 leaves the counter at 3 and sets overflow; overflow clears only on reset.
  - A service decrements the granted player's counter.
  - A hit and a decrement in the same cycle leave the counter unchanged.
- FSM states: IDLE, UPDATE, WAIT_SND, PLAY.
  - IDLE: if any pend is nonzero, choose a player and latch the choice; next state is UPDATE.
  - Arbitration in IDLE: if both pends are nonzero, choose the player not granted last time. The last-grant pointer resets to player 2, so player 1 wins the first tie.
  - UPDATE (one cycle): grant is asserted; the chosen player's score is incremented in BCD and its pend is decremented; next state is WAIT_SND.
  - WAIT_SND: stay while sound_busy=1; go to PLAY when sound_busy=0.
  - PLAY: PlayAgain=1 for exactly SOUND_HOLD cycles, timed by a 4-bit counter; then go to IDLE.
- BCD increment:
  - units 9 → 0 with a carry into tens;
  - tens 9 with a carry → 0, so 99 wraps to 00;
  - digits never leave the range 0..9.
- clr2 effects:
  - next cycle, Number12=Number22=0 and pend2=0;
  - clr2 takes priority over a same-cycle UPDATE increment for player 2 and over a same-cycle hitShot2;
  - the FSM is not disturbed, so an in-flight player-2 sound still plays.
- Reset values (asynchronous, immediate): all digits 0, pend1=pend2=0, overflow=0, PlayAgain=0, grant=00, state IDLE, hold counter 0, last-grant = player 2.
- Reset mid-PLAY drops PlayAgain immediately and discards all queued events.

## Timing
- Reference sequence, hitShot1 high in cycle 0 with sound_busy=0 and SOUND_HOLD=4:

  | Cycle | State / visible effect |
  |---|---|
  | 1 | pend1=1, state IDLE |
  | 2 | state UPDATE, grant=01 |
  | 3 | Number2 incremented, state WAIT_SND |
  | 4–7 | PlayAgain=1 (PLAY) |
  | 8 | state IDLE |

- Minimum service interval: 3 + SOUND_HOLD cycles per event.
- sound_busy stalls only WAIT_SND; score updates are never delayed by the sound unit once UPDATE is reached.
- Hits arriving in any state are captured in the same cycle; none are lost below saturation.
- hitShot1 and hitShot2 high in the same cycle increment both pends.

## Test plan
- Single hit: reset, then one hitShot1 pulse with sound_busy=0 → Number1/Number2 = 0/1 from cycle 3; PlayAgain high cycles 4–7; grant=01 in cycle 2 only.
- Tie and round-robin: hitShot1 and hitShot2 in the same cycle → player 1 serviced first (grant=01), then player 2 (grant=10) 7 cycles later; scores 01/01; PlayAgain produces two 4-cycle pulses.
- BCD wrap: 99 player-1 hits → Number1/Number2 = 9/9; the 100th hit → 0/0; the 10th hit → 1/0 (units carry).
- Saturation: 5 back-to-back hitShot2 pulses while sound_busy=1 → pend2 saturates at 3 and overflow=1. After sound_busy falls, exactly one player-2 point is scored per completed service, ending at 4 total points: one already in UPDATE, then 3 pending.
- Sound stall: sound_busy held high for 20 cycles after UPDATE → FSM remains in WAIT_SND, PlayAgain stays 0, score already incremented; PlayAgain rises the cycle after sound_busy falls.
- Clear and reset: clr2 asserted in the same cycle as a player-2 UPDATE → Number12/Number22 = 0/0. pointresetShot1 asserted mid-PLAY → PlayAgain=0 and all outputs zero immediately, before the next Clock edge.
